// File: rtl/id_stage_if.sv
// Signal bundle between the IF/ID register, the hazard unit and the ID stage.
// master = upstream/testbench side, slave = the ID stage itself.
interface id_stage_if;
  logic [31:0] PC_in;
  logic [31:0] PC_4_in;
  logic [31:0] Instr_in;
  logic [4:0]  ErrStat_IF_to_ID;
  logic        Err_IF_to_ID;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        Stall;
  logic        ErrSignal;

  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        branch;
  logic        jump;
  logic [31:0] branch_addr32;
  logic [31:0] jump_addr32;
  logic        eretEn;
  logic [31:0] PC_EX;
  logic [31:0] PC_8_EX;
  logic [31:0] Instr_EX;
  logic [31:0] rs_data_EX;
  logic [31:0] rt_data_EX;
  logic [31:0] imm_ext_EX;
  logic [4:0]  ErrStat_ID_to_EX;
  logic        Err_ID_to_EX;
  logic        BD_EX;

  modport master (
    output PC_in, PC_4_in, Instr_in, ErrStat_IF_to_ID, Err_IF_to_ID,
           rs_data, rt_data, Stall, ErrSignal,
    input  rs_addr, rt_addr, branch, jump, branch_addr32, jump_addr32, eretEn,
           PC_EX, PC_8_EX, Instr_EX, rs_data_EX, rt_data_EX, imm_ext_EX,
           ErrStat_ID_to_EX, Err_ID_to_EX, BD_EX
  );

  modport slave (
    input  PC_in, PC_4_in, Instr_in, ErrStat_IF_to_ID, Err_IF_to_ID,
           rs_data, rt_data, Stall, ErrSignal,
    output rs_addr, rt_addr, branch, jump, branch_addr32, jump_addr32, eretEn,
           PC_EX, PC_8_EX, Instr_EX, rs_data_EX, rt_data_EX, imm_ext_EX,
           ErrStat_ID_to_EX, Err_ID_to_EX, BD_EX
  );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: decode, branch/jump resolution, RI detection, exception
// merge, delay-slot tracking and the ID/EX pipeline register.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [4:0]  NO_ERR   = 5'd31
) (
  input logic     clk,
  input logic     reset,
  id_stage_if.slave bus
);
  localparam logic [4:0] ERR_RI = 5'd10;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs_f, rt_f;
  logic [15:0] imm16;
  logic [31:0] sext_imm, imm_ext;
  logic        is_br, is_jmp, is_jreg, is_eret, ri, cond, err_merged;
  logic [4:0]  errstat_merged;
  logic        prev_ctrl;

  assign opcode = bus.Instr_in[31:26];
  assign funct  = bus.Instr_in[5:0];
  assign rs_f   = bus.Instr_in[25:21];
  assign rt_f   = bus.Instr_in[20:16];
  assign imm16  = bus.Instr_in[15:0];
  assign sext_imm = {{16{imm16[15]}}, imm16};

  assign bus.rs_addr = rs_f;
  assign bus.rt_addr = rt_f;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    is_br   = 1'b0;
    is_jmp  = 1'b0;
    is_jreg = 1'b0;
    is_eret = 1'b0;
    ri      = 1'b0;
    cond    = 1'b0;
    imm_ext = sext_imm;
    unique case (opcode)
      6'h00: begin
        unique case (funct)
          6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00: ;
          6'h08, 6'h09: begin is_jmp = 1'b1; is_jreg = 1'b1; end
          default: ri = 1'b1;
        endcase
      end
      6'h01: begin
        is_br = 1'b1;
        unique case (rt_f)
          5'd0: cond = $signed(bus.rs_data) <  0;
          5'd1: cond = $signed(bus.rs_data) >= 0;
          default: begin is_br = 1'b0; ri = 1'b1; end
        endcase
      end
      6'h02, 6'h03: is_jmp = 1'b1;
      6'h04: begin is_br = 1'b1; cond = (bus.rs_data == bus.rt_data); end
      6'h05: begin is_br = 1'b1; cond = (bus.rs_data != bus.rt_data); end
      6'h06: begin is_br = 1'b1; cond = ($signed(bus.rs_data) <= 0); end
      6'h07: begin is_br = 1'b1; cond = ($signed(bus.rs_data) >  0); end
      6'h0c, 6'h0d: imm_ext = {16'b0, imm16};
      6'h0f: imm_ext = {imm16, 16'b0};
      6'h09, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b: ;
      6'h10: begin
        if (rs_f == 5'h10 && funct == 6'h18) is_eret = 1'b1;
        else if (rs_f != 5'h00 && rs_f != 5'h04) ri = 1'b1;
      end
      default: ri = 1'b1;
    endcase
  end

  // An IF-side fault or an RI instruction must never redirect fetch.
  assign bus.branch = is_br & cond & ~bus.Err_IF_to_ID & ~ri;
  assign bus.jump   = is_jmp & ~bus.Err_IF_to_ID & ~ri;
  assign bus.eretEn = is_eret & ~bus.Err_IF_to_ID & ~ri;

  assign bus.branch_addr32 = bus.PC_4_in + {sext_imm[29:0], 2'b00};
  assign bus.jump_addr32   = is_jreg ? bus.rs_data
                                     : {bus.PC_4_in[31:28], bus.Instr_in[25:0], 2'b00};

  assign err_merged     = bus.Err_IF_to_ID | ri;
  assign errstat_merged = bus.Err_IF_to_ID ? bus.ErrStat_IF_to_ID
                        : ri               ? ERR_RI : NO_ERR;

  // NOTE: pipeline state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset || bus.ErrSignal) begin
      prev_ctrl            <= 1'b0;
      bus.PC_EX            <= RESET_PC;
      bus.PC_8_EX          <= RESET_PC + 32'd8;
      bus.Instr_EX         <= '0;
      bus.rs_data_EX       <= '0;
      bus.rt_data_EX       <= '0;
      bus.imm_ext_EX       <= '0;
      bus.ErrStat_ID_to_EX <= NO_ERR;
      bus.Err_ID_to_EX     <= 1'b0;
      bus.BD_EX            <= 1'b0;
    end else if (bus.Stall) begin
      // Bubble keeps PC and BD so an interrupt taken on it still has a valid EPC.
      bus.PC_EX            <= bus.PC_in;
      bus.PC_8_EX          <= bus.PC_4_in + 32'd4;
      bus.Instr_EX         <= '0;
      bus.rs_data_EX       <= '0;
      bus.rt_data_EX       <= '0;
      bus.imm_ext_EX       <= '0;
      bus.ErrStat_ID_to_EX <= NO_ERR;
      bus.Err_ID_to_EX     <= 1'b0;
      bus.BD_EX            <= prev_ctrl;
    end else begin
      prev_ctrl            <= is_br | is_jmp;
      bus.PC_EX            <= bus.PC_in;
      bus.PC_8_EX          <= bus.PC_4_in + 32'd4;
      bus.Instr_EX         <= bus.Instr_in;
      bus.rs_data_EX       <= bus.rs_data;
      bus.rt_data_EX       <= bus.rt_data;
      bus.imm_ext_EX       <= imm_ext;
      bus.ErrStat_ID_to_EX <= errstat_merged;
      bus.Err_ID_to_EX     <= err_merged;
      bus.BD_EX            <= prev_ctrl;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed vectors checked with immediate assertions.
module tb_id_stage;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  id_stage_if bus ();

  id_stage #(.RESET_PC(32'h0000_3000), .NO_ERR(5'd31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] rs, input logic [31:0] rt);
    bus.PC_in    = pc;
    bus.PC_4_in  = pc + 32'd4;
    bus.Instr_in = instr;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.Stall = 1'b0;
    bus.ErrSignal = 1'b0;
    bus.Err_IF_to_ID = 1'b0;
    bus.ErrStat_IF_to_ID = 5'd0;
    drive(32'h3400, 32'h0085_1021, 32'd1, 32'd2);
    step();
    step();
    check("rst_pc",      bus.PC_EX,            32'h3000);
    check("rst_pc8",     bus.PC_8_EX,          32'h3008);
    check("rst_instr",   bus.Instr_EX,         32'h0);
    check("rst_rs",      bus.rs_data_EX,       32'h0);
    check("rst_errstat", bus.ErrStat_ID_to_EX, 32'd31);
    check("rst_err",     bus.Err_ID_to_EX,     32'd0);
    check("rst_bd",      bus.BD_EX,            32'd0);

    reset = 1'b0;
    // ori $2,$2,0x8001: zero-extended immediate
    drive(32'h3000, 32'h3442_8001, 32'd0, 32'd0);
    check("ori_rs_addr", bus.rs_addr, 32'd2);
    check("ori_branch",  bus.branch,  32'd0);
    step();
    check("ori_imm", bus.imm_ext_EX, 32'h0000_8001);
    check("ori_bd",  bus.BD_EX,      32'd0);

    // beq $4,$5,-4 taken
    drive(32'h3010, 32'h1085_FFFC, 32'd7, 32'd7);
    check("beq_branch", bus.branch,        32'd1);
    check("beq_target", bus.branch_addr32, 32'h3004);
    check("beq_rt_addr", bus.rt_addr,      32'd5);
    check("beq_jump",   bus.jump,          32'd0);
    step();
    check("beq_pc",    bus.PC_EX,      32'h3010);
    check("beq_pc8",   bus.PC_8_EX,    32'h3018);
    check("beq_instr", bus.Instr_EX,   32'h1085_FFFC);
    check("beq_imm",   bus.imm_ext_EX, 32'hFFFF_FFFC);
    check("beq_rsd",   bus.rs_data_EX, 32'd7);
    check("beq_bd",    bus.BD_EX,      32'd0);

    // delay slot of the beq
    drive(32'h3014, 32'h0085_1021, 32'd7, 32'd7);
    check("addu_branch", bus.branch, 32'd0);
    step();
    check("slot_bd", bus.BD_EX, 32'd1);

    // bne not taken still marks the next instruction as a delay slot
    drive(32'h3018, 32'h1485_FFFC, 32'd7, 32'd7);
    check("bne_nt_branch", bus.branch, 32'd0);
    step();
    check("bne_bd", bus.BD_EX, 32'd0);
    drive(32'h301C, 32'h3C01_8000, 32'd0, 32'd0);
    step();
    check("lui_bd",  bus.BD_EX,      32'd1);
    check("lui_imm", bus.imm_ext_EX, 32'h8000_0000);

    // bltz on a negative operand, and bgez on the same operand
    drive(32'h3100, 32'h0480_0003, 32'h8000_0000, 32'd0);
    check("bltz_branch", bus.branch,        32'd1);
    check("bltz_target", bus.branch_addr32, 32'h3110);
    drive(32'h3100, 32'h0481_0003, 32'h8000_0000, 32'd0);
    check("bgez_branch", bus.branch, 32'd0);
    drive(32'h3100, 32'h1880_0003, 32'h0000_0000, 32'd0);
    check("blez_zero", bus.branch, 32'd1);
    drive(32'h3100, 32'h1C80_0003, 32'h0000_0000, 32'd0);
    check("bgtz_zero", bus.branch, 32'd0);
    step();
    drive(32'h3104, 32'h2442_8001, 32'd0, 32'd0);
    step();
    check("addiu_bd",  bus.BD_EX,      32'd1);
    check("addiu_imm", bus.imm_ext_EX, 32'hFFFF_8001);

    // jal under stall, then released
    bus.Stall = 1'b1;
    drive(32'h3020, 32'h0C00_0C10, 32'd0, 32'd0);
    check("jal_jump",   bus.jump,        32'd1);
    check("jal_target", bus.jump_addr32, 32'h3040);
    step();
    check("stall_instr", bus.Instr_EX,     32'h0);
    check("stall_pc",    bus.PC_EX,        32'h3020);
    check("stall_bd",    bus.BD_EX,        32'd0);
    check("stall_err",   bus.Err_ID_to_EX, 32'd0);
    bus.Stall = 1'b0;
    step();
    check("jal_instr", bus.Instr_EX, 32'h0C00_0C10);
    check("jal_pc8",   bus.PC_8_EX,  32'h3028);

    // jr in the delay slot, stalled: bubble carries BD=1
    bus.Stall = 1'b1;
    drive(32'h3024, 32'h03E0_0008, 32'h1234_5678, 32'd0);
    check("jr_jump",   bus.jump,        32'd1);
    check("jr_target", bus.jump_addr32, 32'h1234_5678);
    step();
    check("bubble_bd", bus.BD_EX, 32'd1);
    check("bubble_pc", bus.PC_EX, 32'h3024);

    // flush together with stall while the delay slot is pending
    bus.ErrSignal = 1'b1;
    step();
    check("flush_pc",    bus.PC_EX,            32'h3000);
    check("flush_pc8",   bus.PC_8_EX,          32'h3008);
    check("flush_instr", bus.Instr_EX,         32'h0);
    check("flush_bd",    bus.BD_EX,            32'd0);
    check("flush_stat",  bus.ErrStat_ID_to_EX, 32'd31);
    bus.ErrSignal = 1'b0;
    bus.Stall = 1'b0;
    drive(32'h3000, 32'h3442_8001, 32'd0, 32'd0);
    step();
    check("post_flush_bd", bus.BD_EX, 32'd0);

    // reserved instructions
    drive(32'h3004, 32'hFC00_0000, 32'd0, 32'd0);
    check("ri_branch", bus.branch, 32'd0);
    check("ri_jump",   bus.jump,   32'd0);
    step();
    check("ri_err",  bus.Err_ID_to_EX,     32'd1);
    check("ri_stat", bus.ErrStat_ID_to_EX, 32'd10);
    drive(32'h3008, 32'h0482_0003, 32'h8000_0000, 32'd0);
    check("ri_regimm_branch", bus.branch, 32'd0);
    step();
    check("ri_regimm_stat", bus.ErrStat_ID_to_EX, 32'd10);

    // eret and mfc0 are legal
    drive(32'h300C, 32'h4200_0018, 32'd0, 32'd0);
    check("eret_en", bus.eretEn, 32'd1);
    step();
    check("eret_err", bus.Err_ID_to_EX, 32'd0);
    drive(32'h3010, 32'h4002_6000, 32'd0, 32'd0);
    check("mfc0_eret", bus.eretEn, 32'd0);
    step();
    check("mfc0_stat", bus.ErrStat_ID_to_EX, 32'd31);

    // IF-side AdEL wins over decode
    bus.Err_IF_to_ID = 1'b1;
    bus.ErrStat_IF_to_ID = 5'd4;
    drive(32'h3011, 32'h0000_0000, 32'd0, 32'd0);
    step();
    check("adel_stat", bus.ErrStat_ID_to_EX, 32'd4);
    check("adel_err",  bus.Err_ID_to_EX,     32'd1);
    drive(32'h3011, 32'hFC00_0000, 32'd0, 32'd0);
    step();
    check("adel_over_ri", bus.ErrStat_ID_to_EX, 32'd4);
    drive(32'h3011, 32'h1085_FFFC, 32'd7, 32'd7);
    check("adel_branch_gate", bus.branch, 32'd0);

    // reset asserted during a stall still clears the register
    bus.Err_IF_to_ID = 1'b0;
    bus.Stall = 1'b1;
    reset = 1'b1;
    drive(32'h3200, 32'h0085_1021, 32'd3, 32'd4);
    step();
    check("rst_stall_pc",  bus.PC_EX,   32'h3000);
    check("rst_stall_pc8", bus.PC_8_EX, 32'h3008);
    reset = 1'b0;
    bus.Stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline with precise exceptions. Sits directly downstream of the IF stage's IF/ID outputs and owns the ID/EX pipeline register.
- Decodes the instruction and resolves branches and jumps in ID, feeding the targets back to IF.
- Detects reserved instructions (RI), merges them with the exception status arriving from IF, and tracks branch-delay-slot (BD) status for EPC/Cause.BD.
- Inserts bubbles on Stall and flushes on ErrSignal.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded into the ID/EX register on reset or flush.
- NO_ERR, 5'd31, ErrStat value meaning "no exception".

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- PC_in  in  32  PC of the instruction in ID (IF/ID register)
- PC_4_in  in  32  PC+4 from IF/ID
- Instr_in  in  32  instruction from IF/ID (0 when IF flagged AdEL)
- ErrStat_IF_to_ID  in  5  exception code from IF
- Err_IF_to_ID  in  1  exception flag from IF
- rs_data  in  32  forwarded GPR[rs]
- rt_data  in  32  forwarded GPR[rt]
- Stall  in  1  hazard-unit stall; IF/ID is held
- ErrSignal  in  1  exception/interrupt flush
- rs_addr  out  5  Instr_in[25:21], combinational, to hazard unit
- rt_addr  out  5  Instr_in[20:16], combinational, to hazard unit
- branch  out  1  conditional branch taken (combinational)
- jump  out  1  j/jal/jr/jalr in ID (combinational)
- branch_addr32  out  32  branch target
- jump_addr32  out  32  jump target
- eretEn  out  1  eret in ID (combinational)
- PC_EX  out  32  registered PC
- PC_8_EX  out  32  registered PC+8 (link value)
- Instr_EX  out  32  registered instruction
- rs_data_EX  out  32  registered rs operand
- rt_data_EX  out  32  registered rt operand
- imm_ext_EX  out  32  registered extended immediate
- ErrStat_ID_to_EX  out  5  registered exception code
- Err_ID_to_EX  out  1  registered exception flag
- BD_EX  out  1  registered delay-slot flag

Behaviour:
- Supported instructions: addu, subu, and, or, slt, sll, addiu, andi, ori, lui, lw, sw, lb, sb, lh, sh, beq, bne, blez, bgtz, bltz, bgez, j, jal, jr, jalr, mfc0, mtc0, eret, nop (all-zero word).
- Any other opcode/funct, or any other REGIMM rt value: RI, code `RI (5'd10).
- Immediate extension:
  - ori/andi: zero-extend.
  - lui: {imm,16'b0}.
  - all others: sign-extend.
- branch_addr32 = PC_4_in + (sext(imm16)<<2), modulo 2^32.
- jump_addr32:
  - j/jal: {PC_4_in[31:28], Instr_in[25:0], 2'b00}.
  - jr/jalr: rs_data.
- Branch conditions use rs_data/rt_data, signed compare for blez/bgtz/bltz/bgez. branch is asserted only when the condition is met.
- branch, jump and eretEn are forced to 0 when Err_IF_to_ID=1 or RI is detected.
- Exception merge: if Err_IF_to_ID=1, pass ErrStat_IF_to_ID (AdEL has priority). Else if RI, code is 10. Else NO_ERR with Err=0.
- BD tracking uses an internal register prev_ctrl:
  - On reset or ErrSignal: prev_ctrl <= 0.
  - On a non-stall cycle: prev_ctrl <= (branch-class or jump-class decoded in ID, taken or not; eret excluded).
  - On a stall cycle: prev_ctrl holds.
  - The BD flag for the instruction in ID equals prev_ctrl.
- ID/EX register update, in priority order:
  1. reset or ErrSignal: PC_EX=RESET_PC, PC_8_EX=RESET_PC+8, Instr_EX=0, rs/rt/imm=0, ErrStat=NO_ERR, Err=0, BD_EX=0.
  2. Stall: bubble. Instr_EX=0, rs/rt/imm=0, Err=0, ErrStat=NO_ERR. PC_EX=PC_in and BD_EX=prev_ctrl, so EPC stays valid if an interrupt hits the bubble.
  3. Otherwise: latch all decoded values. PC_8_EX = PC_4_in + 4.
- Latency: one cycle from ID to EX outputs. Control outputs to IF are zero-latency.
- Reset-mid-operation: reset during Stall still clears everything. ErrSignal concurrent with Stall also flushes.

Test Plan:
- Reset: assert reset for 2 cycles -> PC_EX=0x3000, PC_8_EX=0x3008, Instr_EX=0, ErrStat=31, Err=0, BD_EX=0.
- beq taken: PC_in=0x3010, PC_4_in=0x3014, Instr=0x1085FFFC, rs_data=rt_data=7 -> branch=1, branch_addr32=0x3004. Next instruction: BD_EX=1 one cycle after it leaves ID.
- jal with stall:
  - PC_4_in=0x3024, Instr=0x0C000C10 -> jump=1, jump_addr32=0x3040.
  - Stall=1 that cycle -> Instr_EX=0, PC_EX=0x3020.
  - Release -> Instr_EX=0x0C000C10, PC_8_EX=0x3028.
- RI: Instr=0xFC000000, Err_IF_to_ID=0 -> next cycle Err_ID_to_EX=1, ErrStat=10, branch=jump=0.
- AdEL priority: Err_IF_to_ID=1, ErrStat_IF_to_ID=4, Instr=0 -> ErrStat_ID_to_EX=4, Err=1.
- Flush: ErrSignal=1 together with Stall=1 while a delay slot is pending -> all outputs at reset values, and the following instruction has BD_EX=0.
